// File: rtl/queen_driver_pkg.sv
// Shared types and constants for the QUEEN core driver.
package queen_driver_pkg;

  localparam int unsigned BoardDefault   = 12;
  localparam int unsigned TimeoutDefault = 1000;
  localparam int unsigned FifoDepth      = 8;
  localparam int unsigned FifoCntW       = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StRecv,
    StFin
  } state_e;

endpackage

// File: rtl/queen_pos_fifo.sv
// 8-entry x 8-bit position FIFO ({col, row}) with occupancy count.
module queen_pos_fifo
  import queen_driver_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [7:0]          wdata,
  input  logic                pop,
  output logic [7:0]          rdata,
  output logic [FifoCntW-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(FifoDepth);

  logic [7:0]          mem_q [FifoDepth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [FifoCntW-1:0] count_q;
  logic                do_push, do_pop;

  assign full    = (count_q == FifoCntW'(FifoDepth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + FifoCntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - FifoCntW'(1);
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/queen_driver.sv
// Buffers host queen positions, feeds them to the QUEEN core and captures its result stream.
module queen_driver
  import queen_driver_pkg::*;
#(
  parameter int unsigned BOARD   = BoardDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pos_valid,
  output logic       pos_ready,
  input  logic [3:0] pos_col,
  input  logic [3:0] pos_row,
  input  logic       start,
  input  logic [2:0] start_num,
  output logic       busy,
  output logic       q_in_valid,
  output logic       q_in_valid_num,
  output logic [3:0] q_col,
  output logic [3:0] q_row,
  output logic [2:0] q_in_num,
  input  logic       q_out_valid,
  input  logic [3:0] q_out,
  output logic       res_valid,
  output logic [3:0] res_idx,
  output logic [3:0] res_data,
  output logic       done,
  output logic       timeout,
  output logic       proto_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam int unsigned RcvW  = 5;
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT - 1);
  localparam logic [RcvW-1:0]  BoardLast   = RcvW'(BOARD - 1);

  state_e              state_q, state_d;
  logic [2:0]          left_q, left_d;
  logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [RcvW-1:0]     rcv_q, rcv_d;
  logic                q_in_valid_q, q_in_valid_d;
  logic                q_in_valid_num_q, q_in_valid_num_d;
  logic [3:0]          q_col_q, q_col_d, q_row_q, q_row_d;
  logic [2:0]          q_in_num_q, q_in_num_d;
  logic                res_valid_q, res_valid_d;
  logic [3:0]          res_idx_q, res_idx_d, res_data_q, res_data_d;
  logic                done_q, done_d, timeout_q, timeout_d, proto_err_q, proto_err_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]          fifo_rdata;
  logic [FifoCntW-1:0] fifo_count;

  // Held low during reset so the host cannot push into a FIFO being cleared.
  assign pos_ready = rst_n & ~fifo_full;
  assign fifo_push = pos_valid & pos_ready;

  queen_pos_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({pos_col, pos_row}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d          = state_q;
    left_d           = left_q;
    wait_cnt_d       = wait_cnt_q;
    rcv_d            = rcv_q;
    q_in_valid_d     = 1'b0;
    q_in_valid_num_d = 1'b0;
    q_col_d          = '0;
    q_row_d          = '0;
    q_in_num_d       = '0;
    res_valid_d      = 1'b0;
    res_idx_d        = res_idx_q;
    res_data_d       = res_data_q;
    done_d           = 1'b0;
    timeout_d        = 1'b0;
    proto_err_d      = 1'b0;
    fifo_pop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && start_num != 3'd0 && FifoCntW'(start_num) <= fifo_count) begin
          state_d          = StSend;
          q_in_valid_d     = 1'b1;
          q_in_valid_num_d = 1'b1;
          q_in_num_d       = start_num;
          q_col_d          = fifo_rdata[7:4];
          q_row_d          = fifo_rdata[3:0];
          fifo_pop         = 1'b1;
          left_d           = start_num - 3'd1;
        end
      end
      StSend: begin
        if (left_q != 3'd0) begin
          q_in_valid_d = 1'b1;
          q_col_d      = fifo_rdata[7:4];
          q_row_d      = fifo_rdata[3:0];
          fifo_pop     = 1'b1;
          left_d       = left_q - 3'd1;
        end else begin
          state_d    = StWait;
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        if (q_out_valid) begin
          state_d     = StRecv;
          res_valid_d = 1'b1;
          res_idx_d   = '0;
          res_data_d  = q_out;
          rcv_d       = RcvW'(1);
          if (BoardLast == '0) begin
            state_d = StFin;
            done_d  = 1'b1;
          end
        end else if (wait_cnt_q == TimeoutLast) begin
          state_d   = StFin;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end
      StRecv: begin
        if (q_out_valid) begin
          res_valid_d = 1'b1;
          res_idx_d   = rcv_q[3:0];
          res_data_d  = q_out;
          rcv_d       = rcv_q + RcvW'(1);
          if (rcv_q == BoardLast) begin
            state_d = StFin;
            done_d  = 1'b1;
          end
        end else begin
          state_d     = StFin;
          done_d      = 1'b1;
          proto_err_d = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      left_q           <= '0;
      wait_cnt_q       <= '0;
      rcv_q            <= '0;
      q_in_valid_q     <= 1'b0;
      q_in_valid_num_q <= 1'b0;
      q_col_q          <= '0;
      q_row_q          <= '0;
      q_in_num_q       <= '0;
      res_valid_q      <= 1'b0;
      res_idx_q        <= '0;
      res_data_q       <= '0;
      done_q           <= 1'b0;
      timeout_q        <= 1'b0;
      proto_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      left_q           <= left_d;
      wait_cnt_q       <= wait_cnt_d;
      rcv_q            <= rcv_d;
      q_in_valid_q     <= q_in_valid_d;
      q_in_valid_num_q <= q_in_valid_num_d;
      q_col_q          <= q_col_d;
      q_row_q          <= q_row_d;
      q_in_num_q       <= q_in_num_d;
      res_valid_q      <= res_valid_d;
      res_idx_q        <= res_idx_d;
      res_data_q       <= res_data_d;
      done_q           <= done_d;
      timeout_q        <= timeout_d;
      proto_err_q      <= proto_err_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign q_in_valid     = q_in_valid_q;
  assign q_in_valid_num = q_in_valid_num_q;
  assign q_col          = q_col_q;
  assign q_row          = q_row_q;
  assign q_in_num       = q_in_num_q;
  assign res_valid      = res_valid_q;
  assign res_idx        = res_idx_q;
  assign res_data       = res_data_q;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_queen_driver.sv
// Self-checking bench for queen_driver: directed scenarios plus randomized jobs against a queue model.
module tb_queen_driver;

  localparam int BOARD   = 12;
  localparam int TIMEOUT = 1000;

  logic       clk, rst_n;
  logic       pos_valid, pos_ready;
  logic [3:0] pos_col, pos_row;
  logic       start;
  logic [2:0] start_num;
  logic       busy;
  logic       q_in_valid, q_in_valid_num;
  logic [3:0] q_col, q_row;
  logic [2:0] q_in_num;
  logic       q_out_valid;
  logic [3:0] q_out;
  logic       res_valid;
  logic [3:0] res_idx, res_data;
  logic       done, timeout, proto_err;

  queen_driver #(.BOARD(BOARD), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pos_valid      (pos_valid),
    .pos_ready      (pos_ready),
    .pos_col        (pos_col),
    .pos_row        (pos_row),
    .start          (start),
    .start_num      (start_num),
    .busy           (busy),
    .q_in_valid     (q_in_valid),
    .q_in_valid_num (q_in_valid_num),
    .q_col          (q_col),
    .q_row          (q_row),
    .q_in_num       (q_in_num),
    .q_out_valid    (q_out_valid),
    .q_out          (q_out),
    .res_valid      (res_valid),
    .res_idx        (res_idx),
    .res_data       (res_data),
    .done           (done),
    .timeout        (timeout),
    .proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: positions the FIFO should currently hold, oldest first.
  logic [7:0] mdl[$];
  int tests;
  int fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] c, input logic [3:0] r);
    bit acc;
    acc = (mdl.size() < 8);
    chk("pos_ready", pos_ready, acc);
    pos_valid = 1'b1;
    pos_col   = c;
    pos_row   = r;
    tick();
    pos_valid = 1'b0;
    if (acc) mdl.push_back({c, r});
  endtask

  task automatic send_job(input int n, input bit push_during);
    chk("idle_before_start", busy, 0);
    start     = 1'b1;
    start_num = 3'(n);
    tick();
    start     = 1'b0;
    start_num = '0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = mdl.pop_front();
      chk("q_in_valid", q_in_valid, 1);
      chk("q_in_valid_num", q_in_valid_num, (i == 0));
      chk("q_in_num", q_in_num, (i == 0) ? n : 0);
      chk("q_col", q_col, e[7:4]);
      chk("q_row", q_row, e[3:0]);
      chk("busy_send", busy, 1);
      if (push_during && $urandom_range(0, 1) == 1)
        push_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      else
        tick();
    end
    chk("send_end_quiet", {q_in_valid, q_in_valid_num, q_col, q_row, q_in_num}, 0);
  endtask

  // Core reply: delay idle cycles, then nw words; nw < BOARD models a truncated stream.
  task automatic respond(input int delay, input int nw, input bit seq);
    logic [3:0] d;
    for (int k = 0; k < delay; k++) begin
      chk("wait_busy", busy, 1);
      chk("wait_no_done", done, 0);
      tick();
    end
    for (int w = 0; w < nw; w++) begin
      d = seq ? 4'(w) : 4'($urandom_range(0, 15));
      q_out_valid = 1'b1;
      q_out       = d;
      tick();
      chk("res_valid", res_valid, 1);
      chk("res_idx", res_idx, w);
      chk("res_data", res_data, d);
      if (w == BOARD - 1) begin
        chk("done_ok", done, 1);
        chk("done_ok_timeout", timeout, 0);
        chk("done_ok_proto", proto_err, 0);
      end else begin
        chk("no_early_done", done, 0);
      end
    end
    if (nw < BOARD) begin
      q_out_valid = 1'b0;
      tick();
      chk("proto_done", done, 1);
      chk("proto_flag", proto_err, 1);
      chk("proto_timeout", timeout, 0);
      chk("proto_last_idx", res_idx, nw - 1);
      chk("proto_no_res", res_valid, 0);
    end
    // A stray word during FIN must be dropped.
    q_out_valid = 1'b1;
    q_out       = 4'($urandom_range(0, 15));
    tick();
    q_out_valid = 1'b0;
    chk("after_done_idle", busy, 0);
    chk("after_done_pulse", done, 0);
    chk("after_done_flags", {timeout, proto_err}, 0);
    chk("after_done_no_res", res_valid, 0);
  endtask

  task automatic drain();
    int n;
    while (mdl.size() > 0) begin
      n = (mdl.size() > 7) ? 7 : mdl.size();
      send_job(n, 0);
      respond(0, BOARD, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_done;
    tests       = 0;
    fails       = 0;
    rst_n       = 1'b0;
    pos_valid   = 1'b0;
    pos_col     = '0;
    pos_row     = '0;
    start       = 1'b0;
    start_num   = '0;
    q_out_valid = 1'b0;
    q_out       = '0;

    tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", pos_ready, 0);
    chk("rst_outs", {q_in_valid, q_in_valid_num, q_col, q_row, q_in_num, res_valid, res_idx,
                     res_data, done, timeout, proto_err}, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", pos_ready, 1);

    // Two positions, two-entry job, core returns 0..11.
    push_one(4'd3, 4'd5);
    push_one(4'd7, 4'd1);
    send_job(2, 0);
    respond(0, BOARD, 1);

    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 7);
      while (mdl.size() < n) push_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      send_job(n, 1);
      respond($urandom_range(0, 20), BOARD, 0);
    end

    // Stream drops after five words.
    if (mdl.size() == 0) push_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    send_job(1, 0);
    respond(2, 5, 0);

    // Silent core.
    if (mdl.size() == 0) push_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    send_job(1, 0);
    k_done = 0;
    for (int k = 1; k <= TIMEOUT + 5; k++) begin
      if (done === 1'b1) begin
        k_done = k;
        break;
      end
      tick();
    end
    chk("timeout_latency", k_done, TIMEOUT + 1);
    chk("timeout_flag", timeout, 1);
    chk("timeout_proto", proto_err, 0);
    tick();
    chk("timeout_busy_drop", busy, 0);
    chk("timeout_pulse_end", {done, timeout}, 0);

    // Rejected starts and a full FIFO.
    drain();
    push_one(4'd9, 4'd2);
    start = 1'b1;
    start_num = 3'd3;
    tick();
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_q", q_in_valid, 0);
    start_num = 3'd0;
    tick();
    chk("zero_start_busy", busy, 0);
    // Same-cycle push does not count toward the start check.
    start_num = 3'd2;
    push_one(4'd4, 4'd4);
    start = 1'b0;
    start_num = '0;
    chk("push_same_cycle_busy", busy, 0);
    while (mdl.size() < 8) push_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    push_one(4'hf, 4'hf);
    chk("full_ready_low", pos_ready, 0);
    chk("full_model_size", mdl.size(), 8);
    drain();

    // Reset in the middle of receiving.
    push_one(4'd1, 4'd6);
    send_job(1, 0);
    for (int w = 0; w < 3; w++) begin
      q_out_valid = 1'b1;
      q_out = 4'(w + 5);
      tick();
    end
    #2;
    rst_n = 1'b0;
    q_out_valid = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", pos_ready, 0);
    chk("midrst_outs", {q_in_valid, q_col, q_row, res_valid, res_idx, res_data, done}, 0);
    mdl.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      q_out_valid = 1'b1;
      tick();
      chk("idle_out_ignored", res_valid, 0);
      chk("idle_no_done", done, 0);
    end
    q_out_valid = 1'b0;
    push_one(4'd2, 4'd8);
    push_one(4'd5, 4'd0);
    send_job(2, 1);
    respond(3, BOARD, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
